apb_multi_timer: RTL

//  Parametrised APB3 timer block replacing the single-channel APB timer.
//  NUM_CH independent down-counters; each has a prescaler, periodic or one-shot mode,

---
 rtl/apb_multi_timer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/apb_multi_timer.sv
// APB3 multi-channel down-counter timer: NUM_CH channels with prescaler, one-shot or
// periodic reload, EXTIN gate/clock modes and W1C interrupt status.

module apb_multi_timer_ch #(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd_sel,
    input  logic [1:0]  word,
    input  logic [31:0] wdata,
    input  logic        extin,
    output logic [31:0] rdata,
    output logic        ist,
    output logic        irq_pend
);
    logic                   en, ext_gate, ext_clk, ie, oneshot;
    logic [PRESC_WIDTH-1:0] presc, pcnt;
    logic [CNT_WIDTH-1:0]   value, reload;
    logic [2:0]             sync;
    logic                   ctrl_wr, val_wr, rld_wr, ist_wr;
    logic                   ext_lvl, ext_rise, tick, wrap, strobe, expire;
    logic                   unused_wdata;

    assign ctrl_wr  = wr & (word == 2'd0);
    assign val_wr   = wr & (word == 2'd1);
    assign rld_wr   = wr & (word == 2'd2);
    assign ist_wr   = wr & (word == 2'd3);

    assign ext_lvl  = sync[1];
    assign ext_rise = sync[1] & ~sync[2];
    assign tick     = en & (ext_clk ? ext_rise : (~ext_gate | ext_lvl));
    assign wrap     = tick & (pcnt == presc);
    // A VALUE write in the strobe cycle displaces the strobe entirely
    assign strobe   = wrap & ~val_wr;
    assign expire   = strobe & (value == CNT_WIDTH'(1));
    assign irq_pend = ist & ie;
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            {en, ext_gate, ext_clk, ie, oneshot} <= '0;
            presc  <= '0;
            pcnt   <= '0;
            value  <= '0;
            reload <= '0;
            ist    <= 1'b0;
            sync   <= '0;
        end else begin
            sync <= {sync[1:0], extin};

            if (ctrl_wr)   pcnt <= '0;
            else if (wrap) pcnt <= '0;
            else if (tick) pcnt <= pcnt + 1'b1;

            if (val_wr)
                value <= wdata[CNT_WIDTH-1:0];
            else if (strobe) begin
                if (value != '0)   value <= value - 1'b1;
                else if (!oneshot) value <= reload;
            end

            if (rld_wr) reload <= wdata[CNT_WIDTH-1:0];

            if (expire)                 ist <= 1'b1;
            else if (ist_wr & wdata[0]) ist <= 1'b0;

            if (ctrl_wr) begin
                {oneshot, ie, ext_clk, ext_gate, en} <= wdata[4:0];
                presc <= wdata[8 +: PRESC_WIDTH];
            end else if (expire && oneshot) begin
                en <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_sel) begin
            case (word)
                2'd0: begin
                    rdata[4:0]              = {oneshot, ie, ext_clk, ext_gate, en};
                    rdata[8 +: PRESC_WIDTH] = presc;
                end
                2'd1:    rdata[CNT_WIDTH-1:0] = value;
                2'd2:    rdata[CNT_WIDTH-1:0] = reload;
                default: rdata[0]             = ist;
            endcase
        end
    end
endmodule

module apb_multi_timer #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [11:2]       PADDR,
    input  logic [31:0]       PWDATA,
    input  logic [3:0]        ECOREVNUM,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NUM_CH-1:0] EXTIN,
    output logic [NUM_CH-1:0] TIMERINT,
    output logic              TIMERINT_ALL
);
    localparam logic [7:0] NCH = 8'(NUM_CH);

    logic [7:0]              ch_idx;
    logic [1:0]              word;
    logic                    glb, unmapped, apb_wr, apb_rd;
    logic [NUM_CH-1:0][31:0] ch_rdata;
    logic [NUM_CH-1:0]       ch_ist, ch_pend;

    assign ch_idx   = PADDR[11:4];
    assign word     = PADDR[3:2];
    assign glb      = (ch_idx == 8'hFF);
    assign unmapped = glb ? (word == 2'd1 || word == 2'd2) : (ch_idx >= NCH);
    assign apb_wr   = PSEL & PENABLE & PWRITE;
    assign apb_rd   = PSEL & ~PWRITE & ~PRESET;
    assign PSLVERR  = PSEL & PENABLE & unmapped & ~PRESET;
    assign PREADY   = 1'b1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        apb_multi_timer_ch #(
            .CNT_WIDTH  (CNT_WIDTH),
            .PRESC_WIDTH(PRESC_WIDTH)
        ) u_ch (
            .clk     (PCLK),
            .rst     (PRESET),
            .wr      (apb_wr & (ch_idx == 8'(i))),
            .rd_sel  (apb_rd & (ch_idx == 8'(i))),
            .word    (word),
            .wdata   (PWDATA),
            .extin   (EXTIN[i]),
            .rdata   (ch_rdata[i]),
            .ist     (ch_ist[i]),
            .irq_pend(ch_pend[i])
        );
    end

    // Per-channel read data is already zero unless selected, so OR-merge is enough
    always_comb begin
        PRDATA = '0;
        if (apb_rd && glb) begin
            case (word)
                2'd0:    PRDATA[NUM_CH-1:0] = ch_ist;
                2'd3:    PRDATA[15:0] = {4'(NUM_CH), 6'(CNT_WIDTH), 2'b00, ECOREVNUM};
                default: PRDATA = '0;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) PRDATA = PRDATA | ch_rdata[i];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            TIMERINT     <= '0;
            TIMERINT_ALL <= 1'b0;
        end else begin
            TIMERINT     <= ch_pend;
            TIMERINT_ALL <= |ch_pend;
        end
    end
endmodule
